// File: rtl/dmux_sel_sequencer_pkg.sv
// Shared types for the nibble-demux controller: state encodings, nibble/LED widths and
// a counter-width helper used by both the debouncer and the dwell timer.
package dmux_sel_sequencer_pkg;

  localparam int NIB_W = 4;
  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    S_LO      = 2'd0,
    S_HI      = 2'd1,
    S_AUTO_LO = 2'd2,
    S_AUTO_HI = 2'd3
  } state_e;

  // A counter that must reach n-1 needs $clog2(n) bits, but never fewer than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmux_sel_sequencer_btn_debounce.sv
// Button synchroniser + debouncer: 2-flop sync, level changes after DEB_CYCLES stable
// cycles; press is a one-cycle pulse on the debounced rising edge, no backpressure.
module dmux_sel_sequencer_btn_debounce
  import dmux_sel_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int            CW      = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          db_q, db_d, db_d1_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      db_d1_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      db_q    <= db_d;
      db_d1_q <= db_q;
      cnt_q   <= cnt_d;
    end
  end

  // Decoded from two registered levels, so the pulse itself needs no flop.
  assign press = db_q & ~db_d1_q;

endmodule

// File: rtl/dmux_sel_sequencer.sv
// Demux select/data sequencer: manual button-stepped or auto dwell-timed nibble capture.
// dout is sw delayed one cycle; captures land one edge after press/dwell expiry; no backpressure.
module dmux_sel_sequencer
  import dmux_sel_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int DWELL_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic [NIB_W-1:0] sw,
  input  logic             auto_en,
  output logic             sel,
  output logic [NIB_W-1:0] dout,
  output logic [LED_W-1:0] led,
  output logic             press,
  output logic [1:0]       state
);

  localparam int            DW     = cnt_w(DWELL_CYCLES);
  localparam logic [DW-1:0] DW_MAX = DW'(DWELL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [NIB_W-1:0] dout_q;
  logic [DW-1:0]    dwell_q, dwell_d;

  dmux_sel_sequencer_btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(press)
  );

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    dwell_d = dwell_q;
    unique case (state_q)
      S_LO, S_HI: begin
        dwell_d = '0;
        // auto_en wins over a coincident press: the press is simply dropped.
        if (auto_en) begin
          state_d = S_AUTO_LO;
        end else if (press) begin
          if (state_q == S_LO) led_d[NIB_W-1:0]     = sw;
          else                 led_d[LED_W-1:NIB_W] = sw;
          state_d = (state_q == S_LO) ? S_HI : S_LO;
        end
      end
      S_AUTO_LO, S_AUTO_HI: begin
        if (!auto_en) begin
          state_d = state_q[0] ? S_HI : S_LO;
          dwell_d = '0;
        end else if (dwell_q == DW_MAX) begin
          if (state_q[0]) led_d[LED_W-1:NIB_W] = sw;
          else            led_d[NIB_W-1:0]     = sw;
          state_d = state_q[0] ? S_AUTO_LO : S_AUTO_HI;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = S_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LO;
      led_q   <= '0;
      dout_q  <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      dout_q  <= sw;
      dwell_q <= dwell_d;
    end
  end

  assign sel   = state_q[0];
  assign state = state_q;
  assign dout  = dout_q;
  assign led   = led_q;

endmodule

// File: tb/tb_dmux_sel_sequencer.sv
// Directed bench for dmux_sel_sequencer (DEB_CYCLES=4, DWELL_CYCLES=8, 10 ns clock).
module tb_dmux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [3:0] sw;
  logic       auto_en;
  logic       sel;
  logic [3:0] dout;
  logic [7:0] led;
  logic       press;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;
  int press_seen = 0;

  dmux_sel_sequencer #(.DEB_CYCLES(4), .DWELL_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .btn(btn), .sw(sw), .auto_en(auto_en),
    .sel(sel), .dout(dout), .led(led), .press(press), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (press === 1'b1) press_seen++;

  // Advance n rising edges; inputs change and outputs are read 1 ns after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; btn = 1'(($urandom)); sw = 4'($urandom); auto_en = 1'($urandom);
    step(2);
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL rst_led got %h exp %h", led, 8'h00); end
    n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL rst_sel got %b exp 0", sel); end
    n_cmp++; if (dout !== 4'h0) begin n_err++; $display("FAIL rst_dout got %h exp 0", dout); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", state); end
    n_cmp++; if (press !== 1'b0) begin n_err++; $display("FAIL rst_press got %b exp 0", press); end
    rst = 1'b0; btn = 1'b0; sw = 4'h0; auto_en = 1'b0;
    step(8);
  endtask

  task automatic test_manual;
    int p0;
    p0 = press_seen;
    sw = 4'hA; btn = 1'b1;
    step(5);
    n_cmp++; if (press !== 1'b0) begin n_err++; $display("FAIL man_early_press got %b exp 0", press); end
    step(1);
    n_cmp++; if (press !== 1'b1) begin n_err++; $display("FAIL man_press got %b exp 1", press); end
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL man_led_pre got %h exp 00", led); end
    step(1);
    n_cmp++; if (press !== 1'b0) begin n_err++; $display("FAIL man_press_width got %b exp 0", press); end
    n_cmp++; if (led !== 8'h0A) begin n_err++; $display("FAIL man_led1 got %h exp 0a", led); end
    n_cmp++; if (sel !== 1'b1) begin n_err++; $display("FAIL man_sel1 got %b exp 1", sel); end
    n_cmp++; if (dout !== 4'hA) begin n_err++; $display("FAIL man_dout got %h exp a", dout); end
    btn = 1'b0;
    step(10);
    sw = 4'h5; btn = 1'b1;
    step(7);
    n_cmp++; if (led !== 8'h5A) begin n_err++; $display("FAIL man_led2 got %h exp 5a", led); end
    n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL man_sel2 got %b exp 0", sel); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL man_state2 got %0d exp 0", state); end
    btn = 1'b0;
    step(10);
    n_cmp++; if (press_seen - p0 !== 2) begin n_err++; $display("FAIL man_press_count got %0d exp 2", press_seen - p0); end
  endtask

  task automatic test_bounce;
    int p0;
    p0 = press_seen;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; step(3);
      btn = 1'b0; step(2);
    end
    step(10);
    n_cmp++; if (press_seen !== p0) begin n_err++; $display("FAIL bounce_press got %0d exp %0d", press_seen, p0); end
    n_cmp++; if (led !== 8'h5A) begin n_err++; $display("FAIL bounce_led got %h exp 5a", led); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL bounce_state got %0d exp 0", state); end
  endtask

  task automatic test_auto;
    sw = 4'hF; auto_en = 1'b1;
    step(1);
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL auto_enter got %0d exp 2", state); end
    step(7);
    n_cmp++; if (led !== 8'h5A) begin n_err++; $display("FAIL auto_led_pre got %h exp 5a", led); end
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL auto_state_pre got %0d exp 2", state); end
    step(1);
    n_cmp++; if (led !== 8'h5F) begin n_err++; $display("FAIL auto_led_lo got %h exp 5f", led); end
    n_cmp++; if (sel !== 1'b1) begin n_err++; $display("FAIL auto_sel_hi got %b exp 1", sel); end
    sw = 4'h3;
    step(8);
    n_cmp++; if (led !== 8'h3F) begin n_err++; $display("FAIL auto_led_hi got %h exp 3f", led); end
    n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL auto_sel_lo got %b exp 0", sel); end
    sw = 4'hC;
    step(8);
    n_cmp++; if (led !== 8'h3C) begin n_err++; $display("FAIL auto_led_lo2 got %h exp 3c", led); end
    n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL auto_state_hi got %0d exp 3", state); end
    // Drop auto_en exactly on the edge where the dwell would expire: no capture.
    step(7);
    auto_en = 1'b0; sw = 4'hE;
    step(1);
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL auto_exit_state got %0d exp 1", state); end
    n_cmp++; if (led !== 8'h3C) begin n_err++; $display("FAIL auto_exit_led got %h exp 3c", led); end
  endtask

  task automatic test_collision;
    sw = 4'h9; btn = 1'b1;
    step(6);
    n_cmp++; if (press !== 1'b1) begin n_err++; $display("FAIL coll_press got %b exp 1", press); end
    auto_en = 1'b1;
    step(1);
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL coll_state got %0d exp 2", state); end
    n_cmp++; if (led !== 8'h3C) begin n_err++; $display("FAIL coll_led got %h exp 3c", led); end
  endtask

  task automatic test_reset_mid_auto;
    step(5);
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL rma_state_pre got %0d exp 2", state); end
    rst = 1'b1;
    step(1);
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL rma_led got %h exp 00", led); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rma_state got %0d exp 0", state); end
    n_cmp++; if (dout !== 4'h0) begin n_err++; $display("FAIL rma_dout got %h exp 0", dout); end
    n_cmp++; if (press !== 1'b0) begin n_err++; $display("FAIL rma_press got %b exp 0", press); end
    rst = 1'b0; auto_en = 1'b0; sw = 4'h6;
    step(5);
    n_cmp++; if (press !== 1'b0) begin n_err++; $display("FAIL rma_early_press got %b exp 0", press); end
    step(1);
    n_cmp++; if (press !== 1'b1) begin n_err++; $display("FAIL rma_press_after got %b exp 1", press); end
    step(1);
    n_cmp++; if (led !== 8'h06) begin n_err++; $display("FAIL rma_led_cap got %h exp 06", led); end
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL rma_state_cap got %0d exp 1", state); end
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; sw = 4'h0; auto_en = 1'b0;
    test_reset();
    test_manual();
    test_bounce();
    test_auto();
    test_collision();
    test_reset_mid_auto();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
